// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: parallel load, clear, six shift/rotate modes,
// and a saturating count of shift/rotate operations since the last load, clear or reset.
module universal_shift_reg #(
  parameter int          WIDTH     = 8,
  parameter logic [63:0] RESET_VAL = 64'd0,
  parameter int          CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done,
  output logic             zero
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [WIDTH-1:0] RST_Q   = RESET_VAL[WIDTH-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_q_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;

  // Count saturates at WIDTH so word_done stays up under continued shifting.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

  // Next-state decode for the data word and shift counter.
  always_comb begin
    w_q_next   = r_q;
    w_cnt_next = r_cnt;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          w_q_next   = r_q;
          w_cnt_next = r_cnt;
        end
        MODE_LOAD: begin
          w_q_next   = d;
          w_cnt_next = {CNT_W{1'b0}};
        end
        MODE_SHL: begin
          w_q_next   = {r_q[WIDTH-2:0], sin};
          w_cnt_next = w_cnt_inc;
        end
        MODE_SHR: begin
          w_q_next   = {sin, r_q[WIDTH-1:1]};
          w_cnt_next = w_cnt_inc;
        end
        MODE_ROL: begin
          w_q_next   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_cnt_next = w_cnt_inc;
        end
        MODE_ROR: begin
          w_q_next   = {r_q[0], r_q[WIDTH-1:1]};
          w_cnt_next = w_cnt_inc;
        end
        MODE_ASR: begin
          w_q_next   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
          w_cnt_next = w_cnt_inc;
        end
        MODE_CLR: begin
          // Clear goes to all-zero, deliberately not to the reset value.
          w_q_next   = {WIDTH{1'b0}};
          w_cnt_next = {CNT_W{1'b0}};
        end
        default: begin
          w_q_next   = r_q;
          w_cnt_next = r_cnt;
        end
      endcase
    end else begin
      w_q_next   = r_q;
      w_cnt_next = r_cnt;
    end
  end

  // State register; reset takes priority over enable and mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= RST_Q;
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_q   <= w_q_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign q         = r_q;
  assign shift_cnt = r_cnt;
  assign sout_msb  = r_q[WIDTH-1];
  assign sout_lsb  = r_q[0];
  assign word_done = (r_cnt == CNT_MAX);
  assign zero      = (r_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8, RESET_VAL=8'hA5):
// table of vectors plus a rotate round-trip sequence, checked through a scoreboard queue.
module tb_universal_shift_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHL = 3'b010, SHR = 3'b011;
  localparam logic [2:0] ROL  = 3'b100, ROR  = 3'b101, ASR = 3'b110, CLR = 3'b111;

  typedef struct {
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          sin;
    logic [W-1:0]  eq;
    logic [CW-1:0] ec;
  } vec_t;

  typedef struct {
    logic [W-1:0]  eq;
    logic [CW-1:0] ec;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sin;
  logic [W-1:0]  q;
  logic          sout_msb;
  logic          sout_lsb;
  logic [CW-1:0] shift_cnt;
  logic          word_done;
  logic          zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  universal_shift_reg #(.WIDTH(W), .RESET_VAL(64'h00000000000000A5)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q), .sout_msb(sout_msb), .sout_lsb(sout_lsb),
    .shift_cnt(shift_cnt), .word_done(word_done), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m,
                              input logic [W-1:0] dd, input logic s,
                              input logic [W-1:0] xq, input logic [CW-1:0] xc);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.d = dd; v.sin = s; v.eq = xq; v.ec = xc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected one entry at %0t", $time);
    end else begin
      n_checks--;
      e = sb.pop_front();
      chk("q",         64'(q),         64'(e.eq));
      chk("shift_cnt", 64'(shift_cnt), 64'(e.ec));
      chk("word_done", 64'(word_done), 64'(e.ec == 4'd8));
      chk("zero",      64'(zero),      64'(e.eq == 8'h00));
      chk("sout_msb",  64'(sout_msb),  64'(e.eq[7]));
      chk("sout_lsb",  64'(sout_lsb),  64'(e.eq[0]));
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset = v.rst; en = v.en; mode = v.mode; d = v.d; sin = v.sin;
    e.eq = v.eq; e.ec = v.ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0]  rq;
    logic [CW-1:0] rc;
    logic [W-1:0]  orig;

    reset = 1'b1; en = 1'b0; mode = HOLD; d = 8'h00; sin = 1'b0;

    // Reset, then en=0 with toggling inputs
    vecs.push_back(mk(1'b1, 1'b0, HOLD, 8'h00, 1'b0, 8'hA5, 4'd0));
    vecs.push_back(mk(1'b1, 1'b1, SHL,  8'hFF, 1'b1, 8'hA5, 4'd0));
    vecs.push_back(mk(1'b0, 1'b0, LOAD, 8'hFF, 1'b1, 8'hA5, 4'd0));
    vecs.push_back(mk(1'b0, 1'b0, CLR,  8'h00, 1'b0, 8'hA5, 4'd0));
    vecs.push_back(mk(1'b0, 1'b0, SHL,  8'h3C, 1'b1, 8'hA5, 4'd0));
    // Load and rotate a full word
    vecs.push_back(mk(1'b0, 1'b1, LOAD, 8'h81, 1'b0, 8'h81, 4'd0));
    vecs.push_back(mk(1'b0, 1'b1, ROL,  8'h00, 1'b0, 8'h03, 4'd1));
    vecs.push_back(mk(1'b0, 1'b1, ROL,  8'h00, 1'b1, 8'h06, 4'd2));
    vecs.push_back(mk(1'b0, 1'b1, ROL,  8'h00, 1'b0, 8'h0C, 4'd3));
    vecs.push_back(mk(1'b0, 1'b1, ROL,  8'h00, 1'b1, 8'h18, 4'd4));
    vecs.push_back(mk(1'b0, 1'b1, ROL,  8'h00, 1'b0, 8'h30, 4'd5));
    vecs.push_back(mk(1'b0, 1'b1, ROL,  8'h00, 1'b0, 8'h60, 4'd6));
    vecs.push_back(mk(1'b0, 1'b1, ROL,  8'h00, 1'b0, 8'hC0, 4'd7));
    vecs.push_back(mk(1'b0, 1'b1, ROL,  8'h00, 1'b0, 8'h81, 4'd8));
    vecs.push_back(mk(1'b0, 1'b1, HOLD, 8'h55, 1'b1, 8'h81, 4'd8));
    // Serial deserialise 1,0,1,1,0,0,1,0 then one saturated shift
    vecs.push_back(mk(1'b0, 1'b1, CLR,  8'hFF, 1'b1, 8'h00, 4'd0));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b1, 8'h01, 4'd1));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b0, 8'h02, 4'd2));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b1, 8'h05, 4'd3));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b1, 8'h0B, 4'd4));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b0, 8'h16, 4'd5));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b0, 8'h2C, 4'd6));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b1, 8'h59, 4'd7));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b0, 8'hB2, 4'd8));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b1, 8'h65, 4'd8));
    // ASR vs SHR, ROR wrap
    vecs.push_back(mk(1'b0, 1'b1, LOAD, 8'h90, 1'b0, 8'h90, 4'd0));
    vecs.push_back(mk(1'b0, 1'b1, ASR,  8'h00, 1'b0, 8'hC8, 4'd1));
    vecs.push_back(mk(1'b0, 1'b1, ASR,  8'h00, 1'b0, 8'hE4, 4'd2));
    vecs.push_back(mk(1'b0, 1'b1, LOAD, 8'h90, 1'b1, 8'h90, 4'd0));
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h48, 4'd1));
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h24, 4'd2));
    vecs.push_back(mk(1'b0, 1'b1, LOAD, 8'h01, 1'b0, 8'h01, 4'd0));
    vecs.push_back(mk(1'b0, 1'b1, ROR,  8'h00, 1'b0, 8'h80, 4'd1));
    // Enable gating mid-sequence
    vecs.push_back(mk(1'b0, 1'b1, LOAD, 8'h0F, 1'b0, 8'h0F, 4'd0));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b0, 8'h1E, 4'd1));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b0, 8'h3C, 4'd2));
    vecs.push_back(mk(1'b0, 1'b0, LOAD, 8'hFF, 1'b1, 8'h3C, 4'd2));
    vecs.push_back(mk(1'b0, 1'b0, CLR,  8'h00, 1'b1, 8'h3C, 4'd2));
    vecs.push_back(mk(1'b0, 1'b0, SHR,  8'hAA, 1'b1, 8'h3C, 4'd2));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b0, 8'h78, 4'd3));
    vecs.push_back(mk(1'b0, 1'b1, SHL,  8'h00, 1'b0, 8'hF0, 4'd4));
    // Reset in the middle of an SHR run, then CLR
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b1, 8'hF8, 4'd5));
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b1, 8'hFC, 4'd6));
    vecs.push_back(mk(1'b1, 1'b1, SHR,  8'h00, 1'b1, 8'hA5, 4'd0));
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h52, 4'd1));
    vecs.push_back(mk(1'b0, 1'b1, CLR,  8'h00, 1'b0, 8'h00, 4'd0));
    // LOAD in the cycle the count would saturate
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h00, 4'd1));
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h00, 4'd2));
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h00, 4'd3));
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h00, 4'd4));
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h00, 4'd5));
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h00, 4'd6));
    vecs.push_back(mk(1'b0, 1'b1, SHR,  8'h00, 1'b0, 8'h00, 4'd7));
    vecs.push_back(mk(1'b0, 1'b1, LOAD, 8'h3C, 1'b1, 8'h3C, 4'd0));
    vecs.push_back(mk(1'b0, 1'b1, HOLD, 8'hC3, 1'b1, 8'h3C, 4'd0));

    foreach (vecs[i]) apply(vecs[i]);

    // Random words: ROR by 8 and ROL by 8 must each return to the loaded value
    for (int k = 0; k < 4; k++) begin
      orig = 8'($urandom_range(0, 255));
      rq = orig;
      rc = 4'd0;
      apply(mk(1'b0, 1'b1, LOAD, orig, 1'b0, rq, rc));
      for (int s = 0; s < 2 * W; s++) begin
        if (s < W) rq = {rq[0], rq[7:1]};
        else       rq = {rq[6:0], rq[7]};
        if (rc != 4'd8) rc = rc + 4'd1;
        apply(mk(1'b0, 1'b1, (s < W) ? ROR : ROL, 8'h00, 1'($urandom_range(0, 1)), rq, rc));
        if (s == W - 1) chk("ror_roundtrip", 64'(q), 64'(orig));
      end
      chk("rol_roundtrip", 64'(q), 64'(orig));
    end

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the single-bit enabled D flip-flop.
- Provides a WIDTH-bit register with enable, synchronous reset, parallel load, clear and six shift/rotate modes, all in one clock domain.
- Tracks how many shift/rotate operations have run since the last load. Saturates at WIDTH and flags when a full word has been shifted.
- Used as a serialiser/deserialiser and as a general datapath register in later labs.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 64.
- RESET_VAL, 0, value q takes on reset; WIDTH bits, truncated if wider.
- CNT_W, $clog2(WIDTH+1), width of the shift counter; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  operation enable; when low, all state holds.
- mode  input  3  operation select, sampled only when en=1.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input bit.
- q  output  WIDTH  register contents (registered).
- sout_msb  output  1  equals q[WIDTH-1]; combinational from q.
- sout_lsb  output  1  equals q[0]; combinational from q.
- shift_cnt  output  CNT_W  shift/rotate operations since last load, clear or reset (registered).
- word_done  output  1  high when shift_cnt == WIDTH; combinational from shift_cnt.
- zero  output  1  high when q == 0; combinational from q.

Behaviour:
- All state updates on the rising edge of clk only. Priority order: reset, then en=0, then mode.
- Reset (reset=1 at the edge) overrides en and mode:
  - q <= RESET_VAL, shift_cnt <= 0.
  - Outputs next cycle: word_done=0, sout_msb/sout_lsb from RESET_VAL, zero=(RESET_VAL==0).
- en=0: q and shift_cnt hold; mode, d and sin are ignored.
- en=1, mode decode (next q):
  - 000 HOLD: q unchanged; shift_cnt unchanged.
  - 001 LOAD: q <= d; shift_cnt <= 0.
  - 010 SHL: q <= {q[WIDTH-2:0], sin}.
  - 011 SHR: q <= {sin, q[WIDTH-1:1]}.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; sin ignored.
  - 111 CLR: q <= 0 (not RESET_VAL); shift_cnt <= 0.
- Shift counter:
  - Modes 010 to 110 increment shift_cnt by 1 per enabled cycle.
  - Saturates at WIDTH; never wraps. Further shifts keep shifting q while shift_cnt stays at WIDTH.
- Latency: one cycle from the sampling edge to the new q and shift_cnt. Flags follow the registered values with zero added latency.
- word_done stays high until a LOAD, CLR or reset, or forever under continued shifting.
- Boundaries:
  - Reset asserted mid-shift-sequence discards the sequence; the next cycle after release starts from RESET_VAL with count 0.
  - LOAD in the same cycle that shift_cnt would saturate: the LOAD wins and the count is 0.
  - After WIDTH SHL steps with serial input, q holds the last WIDTH sin bits, first bit in the MSB.
  - ROL/ROR by WIDTH steps returns q to its original value.
  - mode changes are legal every cycle; no internal FSM state beyond q and shift_cnt.
- Fully synchronous: no latches, no asynchronous paths, no X on any output after the first reset edge.

Test Plan (WIDTH=8, RESET_VAL=8'hA5):
- Reset, then hold: reset=1 for 2 edges, release, en=0, toggle mode/d/sin for 3 cycles.
  -> q=8'hA5, shift_cnt=0, word_done=0, zero=0 throughout.
- Load and rotate: LOAD d=8'h81, then ROL for 1 cycle.
  -> q=8'h03, shift_cnt=1.
  -> Continue ROL 7 more cycles: q=8'h81, shift_cnt=8, word_done=1.
- Serial deserialise: CLR, then SHL 8 cycles with sin=1,0,1,1,0,0,1,0.
  -> q=8'hB2, word_done=1 on the cycle after the 8th edge.
  -> A 9th SHL with sin=1: q=8'h65, shift_cnt stays 8.
- ASR vs SHR:
  - LOAD 8'h90, ASR twice -> q=8'hE4.
  - LOAD 8'h90, SHR twice with sin=0 -> q=8'h24.
  - ROR once from 8'h01 -> q=8'h80.
- Enable gating mid-sequence: LOAD 8'h0F, SHL with sin=0 for 2 cycles, en=0 for 3 cycles, SHL 2 more.
  -> q=8'hF0, shift_cnt=4, and it holds at q=8'h3C, shift_cnt=2 during the en=0 gap.
- Reset mid-operation and CLR: during an SHR run, assert reset for 1 edge.
  -> q=8'hA5, shift_cnt=0.
  -> Then CLR: q=8'h00, zero=1, sout_msb=sout_lsb=0.
